// File: rtl/drac_pkg.sv
// Shared front-end types: address widths, icache index/vpn/line types and the
// icache request arbiter state and owner encodings.
package drac_pkg;

  localparam int unsigned ADDR_SIZE  = 40;
  localparam int unsigned IDX_BITS   = 12;
  localparam int unsigned VPN_BITS   = ADDR_SIZE - IDX_BITS;
  localparam int unsigned LINE_BITS  = 128;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [IDX_BITS-1:0]  icache_idx_t;
  typedef logic [VPN_BITS-1:0]  icache_vpn_t;
  typedef logic [LINE_BITS-1:0] icache_line_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_REQ   = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } icache_arb_state_t;

  typedef enum logic {
    OWNER_FETCH    = 1'b0,
    OWNER_PREFETCH = 1'b1
  } icache_owner_t;

  // The icache is virtually indexed: low bits index the set, the rest go to the TLB.
  function automatic icache_idx_t vaddr_idx(input addr_t va);
    return va[IDX_BITS-1:0];
  endfunction

  function automatic icache_vpn_t vaddr_vpn(input addr_t va);
    return va[ADDR_SIZE-1:IDX_BITS];
  endfunction

endpackage

// File: rtl/icache_req_arbiter_if.sv
// Bundle of requester, icache/TLB request and response signals around the
// icache request arbiter; slave is the arbiter side, master the environment.
interface icache_req_arbiter_if;
  import drac_pkg::*;

  logic         flush_i;

  logic         fetch_req_valid_i;
  addr_t        fetch_req_vaddr_i;
  logic         fetch_req_ready_o;

  logic         pf_req_valid_i;
  addr_t        pf_req_vaddr_i;
  logic         pf_req_ready_o;

  logic         icache_req_valid_o;
  logic         icache_req_ready_i;
  icache_idx_t  icache_req_bits_idx_o;
  icache_vpn_t  tlb_req_bits_vpn_o;
  logic         tlb_req_valid_o;
  logic         icache_req_kill_o;

  logic         icache_resp_valid_i;
  icache_line_t icache_resp_datablock_i;
  logic         tlb_resp_xcp_if_i;
  logic         icache_resp_ready_o;

  logic         fetch_resp_valid_o;
  logic         pf_resp_valid_o;
  icache_line_t resp_data_o;
  logic         resp_xcpt_o;

  modport slave (
    input  flush_i,
    input  fetch_req_valid_i, fetch_req_vaddr_i,
    input  pf_req_valid_i, pf_req_vaddr_i,
    input  icache_req_ready_i,
    input  icache_resp_valid_i, icache_resp_datablock_i, tlb_resp_xcp_if_i,
    output fetch_req_ready_o, pf_req_ready_o,
    output icache_req_valid_o, icache_req_bits_idx_o,
    output tlb_req_bits_vpn_o, tlb_req_valid_o, icache_req_kill_o,
    output icache_resp_ready_o,
    output fetch_resp_valid_o, pf_resp_valid_o, resp_data_o, resp_xcpt_o
  );

  modport master (
    output flush_i,
    output fetch_req_valid_i, fetch_req_vaddr_i,
    output pf_req_valid_i, pf_req_vaddr_i,
    output icache_req_ready_i,
    output icache_resp_valid_i, icache_resp_datablock_i, tlb_resp_xcp_if_i,
    input  fetch_req_ready_o, pf_req_ready_o,
    input  icache_req_valid_o, icache_req_bits_idx_o,
    input  tlb_req_bits_vpn_o, tlb_req_valid_o, icache_req_kill_o,
    input  icache_resp_ready_o,
    input  fetch_resp_valid_o, pf_resp_valid_o, resp_data_o, resp_xcpt_o
  );

endinterface

// File: rtl/icache_req_arbiter.sv
// Arbitrates demand fetch and prefetch requests onto a single icache/TLB port
// with one access outstanding, and routes the response back to its owner.
module icache_req_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  icache_req_arbiter_if.slave  bus
);
  import drac_pkg::*;

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  icache_arb_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  addr_t             vaddr_q, vaddr_d;
  icache_owner_t     owner_q, owner_d;

  logic         fetch_ready;
  logic         pf_ready;
  logic         req_valid;
  logic         req_kill;
  logic         resp_ready;
  logic         fetch_resp_valid;
  logic         pf_resp_valid;
  icache_line_t resp_data;
  logic         resp_xcpt;
  logic         pf_wins;

  // Prefetch only beats a valid fetch once it has been passed over STARVE_LIMIT times.
  assign pf_wins = bus.pf_req_valid_i &&
                   (!bus.fetch_req_valid_i || (cnt_q == CNT_MAX));

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    vaddr_d          = vaddr_q;
    owner_d          = owner_q;
    fetch_ready      = 1'b0;
    pf_ready         = 1'b0;
    req_valid        = 1'b0;
    req_kill         = 1'b0;
    resp_ready       = 1'b0;
    fetch_resp_valid = 1'b0;
    pf_resp_valid    = 1'b0;
    resp_data        = '0;
    resp_xcpt        = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // Readies are gated by rst_i so nothing is granted while reset is held.
        if (!rst_i && !bus.flush_i &&
            (bus.fetch_req_valid_i || bus.pf_req_valid_i)) begin
          state_d = ARB_REQ;
          if (pf_wins) begin
            pf_ready = 1'b1;
            owner_d  = OWNER_PREFETCH;
            vaddr_d  = bus.pf_req_vaddr_i;
            cnt_d    = '0;
          end else begin
            fetch_ready = 1'b1;
            owner_d     = OWNER_FETCH;
            vaddr_d     = bus.fetch_req_vaddr_i;
            if (bus.pf_req_valid_i && (cnt_q < CNT_MAX)) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ARB_REQ: begin
        if (bus.flush_i) begin
          req_kill = 1'b1;
          state_d  = ARB_IDLE;
        end else begin
          req_valid = 1'b1;
          if (bus.icache_req_ready_i) begin
            state_d = ARB_WAIT;
          end
        end
      end

      ARB_WAIT: begin
        resp_ready = 1'b1;
        if (bus.icache_resp_valid_i) begin
          state_d = ARB_IDLE;
          if (!bus.flush_i) begin
            fetch_resp_valid = (owner_q == OWNER_FETCH);
            pf_resp_valid    = (owner_q == OWNER_PREFETCH);
            resp_data        = bus.icache_resp_datablock_i;
            resp_xcpt        = bus.tlb_resp_xcp_if_i;
          end
        end else if (bus.flush_i) begin
          req_kill = 1'b1;
          state_d  = ARB_DRAIN;
        end
      end

      ARB_DRAIN: begin
        // The killed access still returns a response; swallow it before the next grant.
        resp_ready = 1'b1;
        if (bus.icache_resp_valid_i) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      vaddr_q <= '0;
      owner_q <= OWNER_FETCH;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vaddr_q <= vaddr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.fetch_req_ready_o     = fetch_ready;
  assign bus.pf_req_ready_o        = pf_ready;
  assign bus.icache_req_valid_o    = req_valid;
  assign bus.tlb_req_valid_o       = req_valid;
  assign bus.icache_req_kill_o     = req_kill;
  assign bus.icache_req_bits_idx_o = vaddr_idx(vaddr_q);
  assign bus.tlb_req_bits_vpn_o    = vaddr_vpn(vaddr_q);
  assign bus.icache_resp_ready_o   = resp_ready;
  assign bus.fetch_resp_valid_o    = fetch_resp_valid;
  assign bus.pf_resp_valid_o       = pf_resp_valid;
  assign bus.resp_data_o           = resp_data;
  assign bus.resp_xcpt_o           = resp_xcpt;

endmodule

// File: doc/icache_req_arbiter.md
ICACHE_REQ_ARBITER -- requirements
Module: icache_req_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive demand grants tolerated while a prefetch waits.
REQ-002 SHALL have clk_i  in  1  clock; single clock domain, rising edge.
REQ-003 SHALL have rst_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have flush_i  in  1  pipeline flush; kills pending or outstanding access.
REQ-005 SHALL have fetch_req_valid_i  in  1, fetch_req_vaddr_i  in  40, fetch_req_ready_o  out  1  demand requester.
REQ-006 SHALL have pf_req_valid_i  in  1, pf_req_vaddr_i  in  40, pf_req_ready_o  out  1  prefetch requester.
REQ-007 SHALL have icache_req_valid_o  out  1, icache_req_ready_i  in  1, icache_req_bits_idx_o  out  12 (vaddr[11:0]), tlb_req_bits_vpn_o  out  28 (vaddr[39:12]), tlb_req_valid_o  out  1, icache_req_kill_o  out  1.
REQ-008 SHALL have icache_resp_valid_i  in  1, icache_resp_datablock_i  in  128, tlb_resp_xcp_if_i  in  1, icache_resp_ready_o  out  1.
REQ-009 SHALL have fetch_resp_valid_o  out  1, pf_resp_valid_o  out  1, resp_data_o  out  128, resp_xcpt_o  out  1  routed response.

Function
REQ-010 SHALL implement FSM states Idle, Req, Wait, Drain; at most one access outstanding.
REQ-011 Idle: SHALL grant when any requester is valid and flush_i=0; ready_o of the winner high in that cycle only; next state Req.
REQ-012 Arbitration SHALL favour fetch; prefetch wins if fetch not valid, or if pf valid and starve counter == STARVE_LIMIT.
REQ-013 Starve counter (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, on each fetch grant with pf_req_valid_i=1; clear on pf grant.
REQ-014 On grant SHALL register vaddr and owner; idx/vpn outputs driven from that register, stable until next grant.
REQ-015 Req: icache_req_valid_o=1 and tlb_req_valid_o=1; on icache_req_ready_i=1 go Wait.
REQ-016 Wait: icache_resp_ready_o=1; on icache_resp_valid_i SHALL pulse owner's resp_valid_o for one cycle with resp_data_o=datablock, resp_xcpt_o=tlb_resp_xcp_if_i, same cycle (combinational); next Idle.
REQ-017 Flush in Req: icache_req_valid_o SHALL drop to 0 in that cycle, icache_req_kill_o=1 that cycle, next Idle.
REQ-018 Flush in Wait without resp_valid: kill=1 that cycle, next Drain; Drain holds resp_ready=1, discards response (no resp_valid_o), returns Idle on icache_resp_valid_i.
REQ-019 Flush coincident with icache_resp_valid_i in Wait or Drain: response SHALL be discarded, next Idle.
REQ-020 Flush in Idle: no grant that cycle; both ready_o=0.
REQ-021 Never SHALL both fetch_resp_valid_o and pf_resp_valid_o be high; never both ready_o high.
REQ-022 resp_data_o SHALL be 0 when no resp_valid_o is high.

Reset
REQ-023 rst_i=1 SHALL asynchronously force state Idle, counter 0, address register 0, owner fetch, all outputs 0.
REQ-024 Reset mid-access SHALL abandon the access; a late icache response after release SHALL be ignored (Idle does not accept responses; icache_resp_ready_o=0).

Structure
REQ-025 icache_arb_state_t (Idle, Req, Wait, Drain) and icache_owner_t (Fetch, Prefetch) SHALL live in drac_pkg; ADDR_SIZE, icache_idx_t, icache_vpn_t, icache_line_t reused from drac_pkg.
REQ-026 No sub-module; FSM, arbiter and counter SHALL be in one module (~200 lines).

Verification
REQ-027 Fetch only, vaddr 0x00_0000_1040: ready_o same cycle, idx=0x040, vpn=0x0000001; ready_i next cycle; resp 0xAA..AA -> fetch_resp_valid_o 1 cycle, data 0xAA..AA.
REQ-028 Both valid continuously, STARVE_LIMIT=4 -> grant order F,F,F,F,P,F,F,F,F,P; counter clears after P.
REQ-029 Flush in Wait, response arrives 3 cycles later -> kill pulse 1 cycle, no resp_valid_o, return Idle, next grant served normally.
REQ-030 Flush same cycle as icache_resp_valid_i -> no resp_valid_o, Idle next cycle.
REQ-031 Prefetch grant with tlb_resp_xcp_if_i=1 on response -> pf_resp_valid_o=1, resp_xcpt_o=1, fetch_resp_valid_o=0.
REQ-032 rst_i asserted in Req with icache_req_ready_i low -> all outputs 0 immediately, Idle after release, stray resp_valid ignored.
